// File: rtl/axi_pkg.sv
// axi_pkg: shared FSM states, AXI3 constants and the write-enable to AW size/address mapping
package axi_pkg;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_RESP, DONE} state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [2:0] SIZE_1     = 3'd0;
    localparam logic [2:0] SIZE_2     = 3'd1;
    localparam logic [2:0] SIZE_4     = 3'd2;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
    } aw_beat_t;

    function automatic aw_beat_t wen_to_size_addr(input logic [3:0] wen, input logic [31:0] addr);
        aw_beat_t r;
        logic     half;
        logic     one_hot;
        half    = (wen == 4'b0011) || (wen == 4'b1100);
        one_hot = (wen != 4'd0) && ((wen & (wen - 4'd1)) == 4'd0);
        r.size  = (wen == 4'b1111) ? SIZE_4 : half ? SIZE_2 : one_hot ? SIZE_1 : SIZE_4;
        r.addr  = (r.size == SIZE_4) ? {addr[31:2], 2'b00} :
                  (r.size == SIZE_2) ? {addr[31:1], 1'b0} : addr;
        return r;
    endfunction

endpackage

// File: rtl/data_sram_axi_bridge_if.sv
// data_sram_axi_bridge_if: AXI3 single-beat bus between the bridge (master) and the slave
interface data_sram_axi_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid, arready;
    logic [3:0]          arid, arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [3:0]          rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast, rvalid, rready;
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awsize;
    logic                awvalid, awready;
    logic [3:0]          awid, awlen;
    logic [1:0]          awburst;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast, wvalid, wready;
    logic [3:0]          wid;
    logic [3:0]          bid;
    logic [1:0]          bresp;
    logic                bvalid, bready;

    modport master (
        output araddr, arvalid, arid, arlen, arsize, arburst, rready,
               awaddr, awsize, awvalid, awid, awlen, awburst,
               wdata, wstrb, wlast, wvalid, wid, bready,
        input  arready, rid, rdata, rresp, rlast, rvalid,
               awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, arid, arlen, arsize, arburst, rready,
               awaddr, awsize, awvalid, awid, awlen, awburst,
               wdata, wstrb, wlast, wvalid, wid, bready,
        output arready, rid, rdata, rresp, rlast, rvalid,
               awready, wready, bid, bresp, bvalid
    );

endinterface

// File: rtl/data_sram_axi_bridge.sv
// data_sram_axi_bridge: turns each SRAM-style data access into one single-beat AXI3 read or write, stalling until done
module data_sram_axi_bridge
    import axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd1,
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_en,
    input  logic [3:0]          req_wen,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                stall,
    output logic                bus_err,
    data_sram_axi_bridge_if.master axi
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        resp_q;
    logic              aw_done, w_done;
    logic              aw_hs, w_hs, r_hit, b_hit;
    aw_beat_t          aw;

    assign aw_hs = axi.awvalid && axi.awready;
    assign w_hs  = axi.wvalid && axi.wready;
    assign r_hit = axi.rvalid && (axi.rid == AXI_ID);
    assign b_hit = axi.bvalid && (axi.bid == AXI_ID);
    assign aw    = wen_to_size_addr(wen_q, addr_q);

    assign axi.araddr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign axi.arid    = AXI_ID;
    assign axi.arlen   = 4'd0;
    assign axi.arsize  = SIZE_4;
    assign axi.arburst = BURST_INCR;
    assign axi.awaddr  = aw.addr;
    assign axi.awsize  = aw.size;
    assign axi.awid    = AXI_ID;
    assign axi.awlen   = 4'd0;
    assign axi.awburst = BURST_INCR;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wen_q;
    assign axi.wlast   = 1'b1;
    assign axi.wid     = AXI_ID;

    // state register
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nxt;

    // next-state: AW and W complete independently, B is awaited only after both
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_en) state_nxt = (req_wen == 4'd0) ? RD_REQ : WR_REQ;
            RD_REQ:  if (axi.arvalid && axi.arready) state_nxt = RD_WAIT;
            RD_WAIT: if (r_hit) state_nxt = DONE;
            WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_RESP;
            WR_RESP: if (b_hit) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // outputs: valids/readies follow state, stall releases only in DONE or an idle cycle
    always_comb begin
        stall       = (state == IDLE) ? req_en : (state != DONE);
        axi.arvalid = state == RD_REQ;
        axi.rready  = state == RD_WAIT;
        axi.awvalid = (state == WR_REQ) && !aw_done;
        axi.wvalid  = (state == WR_REQ) && !w_done;
        axi.bready  = state == WR_RESP;
        bus_err     = (state == DONE) && (resp_q != RESP_OKAY);
    end

    // request latch, per-channel handshake flags and response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            wen_q      <= '0;
            wdata_q    <= '0;
            resp_q     <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            resp_rdata <= '0;
        end else begin
            if (state == IDLE && req_en) begin
                addr_q  <= req_addr;
                wen_q   <= req_wen;
                wdata_q <= req_wdata;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (state == WR_REQ) begin
                aw_done <= aw_done || aw_hs;
                w_done  <= w_done || w_hs;
            end
            if (state == RD_WAIT && r_hit) begin
                resp_rdata <= axi.rdata;
                resp_q     <= axi.rresp;
            end
            if (state == WR_RESP && b_hit)
                resp_q <= axi.bresp;
        end
    end

endmodule
